chunked_serial_adder: RTL and testbench

//  Multi-cycle N-bit adder/subtractor. Adds CHUNK bits per clock, ripple carry held in a register.

---
 rtl/chunked_serial_adder.sv | 114 +++++++++++
 tb/tb_chunked_serial_adder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that adds CHUNK bits per clock through a
// registered ripple carry, with valid/ready handshakes on operand and result sides.
module chunked_serial_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int MSB    = WIDTH - 1;

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
   end

   // Handshake: a transfer happens on a rising edge where valid and ready are both
   // high; valid is never withdrawn by the block, and results hold until taken.
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic             carry_q;
   logic [IDX_W-1:0] idx_q;

   int               lsb;
   logic [CHUNK-1:0] a_ch, b_ch, s_ch;
   logic             c_nxt;
   logic             last;

   always_comb begin
      lsb           = int'(idx_q) * CHUNK;
      a_ch          = a_q[lsb +: CHUNK];
      b_ch          = b_q[lsb +: CHUNK];
      {c_nxt, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
      last          = (idx_q == IDX_W'(NCHUNK - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_d = ADD;
         end
         ADD: begin
            if (last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         out_sum  <= '0;
         out_cout <= 1'b0;
         out_ovf  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is A + ~B + 1; the carry-in is replaced by the +1.
                  a_q     <= in_a;
                  b_q     <= in_sub ? ~in_b : in_b;
                  carry_q <= in_sub | in_cin;
                  idx_q   <= '0;
               end
            end
            ADD: begin
               out_sum[lsb +: CHUNK] <= s_ch;
               carry_q               <= c_nxt;
               idx_q                 <= idx_q + IDX_W'(1);
               if (last) begin
                  out_cout <= c_nxt;
                  out_ovf  <= (a_q[MSB] == b_q[MSB]) && (s_ch[CHUNK-1] != a_q[MSB]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: three configurations (W8/C2, W2/C1, W8/C8) driven
// with directed and random operations against a signed/unsigned arithmetic model.
module tb_chunked_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] vin = '0, cin_i = '0, sub_i = '0, ordy = '0;
   logic [7:0] a_i [3];
   logic [7:0] b_i [3];
   wire  [2:0] irdy, ovld, cout_o, ovf_o, busy_o;
   wire  [7:0] sum_o [3];
   wire  [1:0] sum1;

   int n_assert = 0;
   int n_fail   = 0;
   logic [9:0] exp_q [$];
   logic [7:0] last_sum;
   logic       last_cout, last_ovf;

   always #5 clk = ~clk;

   assign sum_o[1] = {6'b0, sum1};

   chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(vin[0]), .in_ready(irdy[0]),
      .in_a(a_i[0]), .in_b(b_i[0]), .in_cin(cin_i[0]), .in_sub(sub_i[0]),
      .out_valid(ovld[0]), .out_ready(ordy[0]), .out_sum(sum_o[0]),
      .out_cout(cout_o[0]), .out_ovf(ovf_o[0]), .busy(busy_o[0]));

   chunked_serial_adder #(.WIDTH(2), .CHUNK(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(vin[1]), .in_ready(irdy[1]),
      .in_a(a_i[1][1:0]), .in_b(b_i[1][1:0]), .in_cin(cin_i[1]), .in_sub(sub_i[1]),
      .out_valid(ovld[1]), .out_ready(ordy[1]), .out_sum(sum1),
      .out_cout(cout_o[1]), .out_ovf(ovf_o[1]), .busy(busy_o[1]));

   chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(vin[2]), .in_ready(irdy[2]),
      .in_a(a_i[2]), .in_b(b_i[2]), .in_cin(cin_i[2]), .in_sub(sub_i[2]),
      .out_valid(ovld[2]), .out_ready(ordy[2]), .out_sum(sum_o[2]),
      .out_cout(cout_o[2]), .out_ovf(ovf_o[2]), .busy(busy_o[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int width_of(input int k);
      return (k == 1) ? 2 : 8;
   endfunction

   // Reference: unsigned result/carry and true signed range check on the operands.
   function automatic logic [9:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic s);
      longint m, ua, ub, sa, sb, u, r;
      logic co, ov;
      m  = (longint'(1) << w) - 1;
      ua = longint'(a) & m;
      ub = longint'(b) & m;
      sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
      sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
      if (s) begin
         u  = ua - ub;
         co = (ua >= ub);
         r  = sa - sb;
      end else begin
         u  = ua + ub + longint'(c);
         co = (u > m);
         r  = sa + sb + longint'(c);
      end
      ov = (r < -(longint'(1) << (w - 1))) || (r > (longint'(1) << (w - 1)) - 1);
      return {ov, co, 8'(u & m)};
   endfunction

   task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic s);
      int waited = 0;
      @(negedge clk);
      while (!irdy[k] && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check($sformatf("in_ready before issue k%0d", k), 32'(irdy[k]), 32'd1);
      vin[k] = 1'b1; a_i[k] = a; b_i[k] = b; cin_i[k] = c; sub_i[k] = s;
      exp_q.push_back(model(width_of(k), a, b, c, s));
      @(posedge clk);
      #1;
      vin[k] = 1'b0;
      check($sformatf("busy after accept k%0d", k), 32'(busy_o[k]), 32'd1);
   endtask

   task automatic wait_valid(input int k, input int lat_exp);
      int cnt = 0;
      logic [9:0] e;
      logic [7:0] m;
      do begin
         @(posedge clk);
         #1;
         cnt++;
      end while (!ovld[k] && cnt < 20);
      check($sformatf("latency k%0d", k), 32'(cnt), 32'(lat_exp));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
      m = 8'((1 << width_of(k)) - 1);
      last_sum = sum_o[k]; last_cout = cout_o[k]; last_ovf = ovf_o[k];
      check($sformatf("sum k%0d", k), 32'(last_sum & m), 32'(e[7:0]));
      check($sformatf("cout k%0d", k), 32'(last_cout), 32'(e[8]));
      check($sformatf("ovf k%0d", k), 32'(last_ovf), 32'(e[9]));
   endtask

   task automatic accept(input int k);
      @(negedge clk);
      ordy[k] = 1'b1;
      @(posedge clk);
      #1;
      ordy[k] = 1'b0;
      check($sformatf("out_valid drop k%0d", k), 32'(ovld[k]), 32'd0);
      check($sformatf("in_ready after done k%0d", k), 32'(irdy[k]), 32'd1);
   endtask

   task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic s, input int lat);
      issue(k, a, b, c, s);
      wait_valid(k, lat);
      accept(k);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         a_i[k] = '0;
         b_i[k] = '0;
      end
      #12;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset in_ready k%0d", k), 32'(irdy[k]), 32'd1);
         check($sformatf("reset out_valid k%0d", k), 32'(ovld[k]), 32'd0);
         check($sformatf("reset busy k%0d", k), 32'(busy_o[k]), 32'd0);
         check($sformatf("reset sum k%0d", k), 32'(sum_o[k]), 32'd0);
         check($sformatf("reset flags k%0d", k), 32'({cout_o[k], ovf_o[k]}), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 4);
      check("5A+3C sum", 32'(last_sum), 32'h96);
      check("5A+3C flags", 32'({last_cout, last_ovf}), 32'b01);
      run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 4);
      check("FF+01 sum", 32'(last_sum), 32'h00);
      check("FF+01 flags", 32'({last_cout, last_ovf}), 32'b10);
      run_op(0, 8'hFF, 8'h00, 1'b1, 1'b0, 4);
      check("FF+00+1 sum", 32'(last_sum), 32'h00);
      check("FF+00+1 cout", 32'(last_cout), 32'd1);
      run_op(0, 8'h10, 8'h20, 1'b1, 1'b1, 4);
      check("10-20 sum", 32'(last_sum), 32'hF0);
      check("10-20 flags", 32'({last_cout, last_ovf}), 32'b00);
      run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 4);
      check("80-01 sum", 32'(last_sum), 32'h7F);
      check("80-01 flags", 32'({last_cout, last_ovf}), 32'b11);

      // Backpressure: result must stay frozen and new operands must be ignored.
      issue(0, 8'hC3, 8'h77, 1'b1, 1'b0);
      wait_valid(0, 4);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vin[0] = 1'b1;
         a_i[0] = 8'($urandom);
         b_i[0] = 8'($urandom);
         @(posedge clk);
         #1;
         check("bp out_valid", 32'(ovld[0]), 32'd1);
         check("bp in_ready", 32'(irdy[0]), 32'd0);
         check("bp hold", 32'({sum_o[0], cout_o[0], ovf_o[0]}),
               32'({last_sum, last_cout, last_ovf}));
      end
      vin[0] = 1'b0;
      accept(0);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("bp no queued op", 32'({ovld[0], busy_o[0]}), 32'd0);
      end

      // Asynchronous reset two cycles into ADD.
      issue(0, 8'hAB, 8'h11, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("mid-reset in_ready", 32'(irdy[0]), 32'd1);
      check("mid-reset valid/busy", 32'({ovld[0], busy_o[0]}), 32'd0);
      check("mid-reset outputs", 32'({sum_o[0], cout_o[0], ovf_o[0]}), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 4);

      for (int i = 0; i < 30; i++)
         run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 4);

      for (int s = 0; s < 2; s++)
         for (int c = 0; c < 2; c++)
            for (int a = 0; a < 4; a++)
               for (int b = 0; b < 4; b++)
                  run_op(1, 8'(a), 8'(b), 1'(c), 1'(s), 2);

      run_op(2, 8'h80, 8'h80, 1'b0, 1'b0, 1);
      run_op(2, 8'h00, 8'h80, 1'b0, 1'b1, 1);
      for (int i = 0; i < 40; i++)
         run_op(2, 8'($urandom), 8'($urandom_range(255, 0)), 1'($urandom), 1'($urandom), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
